// File: rtl/rtc_spi_pkg.sv
// rtl/rtc_spi_pkg.sv - shared types and constants for the RTC SPI port
package rtc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2
    } spi_state_t;

    localparam logic SEL_DATA = 1'b0;
    localparam logic SEL_CTRL = 1'b1;

    localparam int STAT_BUSY    = 7;
    localparam int STAT_OVERRUN = 6;
    localparam int STAT_INT     = 2;
    localparam int STAT_PWRFAIL = 1;
    localparam int STAT_CS      = 0;

    localparam int CLK_DIV_DEFAULT = 25;

    function automatic logic [7:0] pack_status(
        input logic busy,
        input logic overrun,
        input logic int_act,
        input logic pwr_fail,
        input logic cs_act
    );
        logic [7:0] s;
        s               = 8'h00;
        s[STAT_BUSY]    = busy;
        s[STAT_OVERRUN] = overrun;
        s[STAT_INT]     = int_act;
        s[STAT_PWRFAIL] = pwr_fail;
        s[STAT_CS]      = cs_act;
        return s;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous bit
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rtc_spi_port.sv
// rtl/rtc_spi_port.sv - CPU-facing SPI mode 3 master for the real-time clock
module rtc_spi_port
    import rtc_spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       pll0_100MHz,
    input  logic       s100_n_RESET,
    input  logic       io_wr,
    input  logic       io_rd,
    input  logic       io_sel,
    input  logic [7:0] io_din,
    output logic [7:0] io_dout,
    input  logic       rtcSpiSO,
    input  logic       rtc_n_INT,
    input  logic       rtcPwrFail,
    output logic       rtcSpiCS,
    output logic       rtcSpiClk,
    output logic       rtcSpiSI,
    output logic       rtcIntLED
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    spi_state_t state, next_state;

    logic [7:0] cnt;
    logic [2:0] bitcnt;
    logic [7:0] shift;
    logic [7:0] rx;
    logic       busy;
    logic       overrun;
    logic       cs_act;
    logic       si_q;
    logic       int_n_sync;
    logic       pwr_fail_sync;

    logic load_tx;
    logic sample_so;
    logic next_bit;
    logic finish;
    logic ovr_set;
    logic ovr_clr;
    logic ctrl_wr;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_int (
        .clk   (pll0_100MHz),
        .rst_n (s100_n_RESET),
        .d     (rtc_n_INT),
        .q     (int_n_sync)
    );

    sync_2ff #(.RESET_VAL(1'b0)) u_sync_pwr (
        .clk   (pll0_100MHz),
        .rst_n (s100_n_RESET),
        .d     (rtcPwrFail),
        .q     (pwr_fail_sync)
    );

    always_ff @(posedge pll0_100MHz or negedge s100_n_RESET) begin
        if (!s100_n_RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_tx    = 1'b0;
        sample_so  = 1'b0;
        next_bit   = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (io_wr && (io_sel == SEL_DATA)) begin
                    next_state = ST_SHIFT_LO;
                    load_tx    = 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (cnt == 8'd0) begin
                    next_state = ST_SHIFT_HI;
                    sample_so  = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (cnt == 8'd0) begin
                    if (bitcnt == 3'd0) begin
                        next_state = ST_IDLE;
                        finish     = 1'b1;
                    end else begin
                        next_state = ST_SHIFT_LO;
                        next_bit   = 1'b1;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Any write landing on a busy port is dropped and only leaves the sticky flag.
    assign ovr_set = io_wr && busy;
    assign ovr_clr = io_rd && (io_sel == SEL_CTRL);
    assign ctrl_wr = io_wr && (io_sel == SEL_CTRL) && !busy;

    always_ff @(posedge pll0_100MHz or negedge s100_n_RESET) begin
        if (!s100_n_RESET) begin
            cnt     <= 8'd0;
            bitcnt  <= 3'd0;
            shift   <= 8'h00;
            rx      <= 8'h00;
            busy    <= 1'b0;
            overrun <= 1'b0;
            cs_act  <= 1'b0;
            si_q    <= 1'b1;
        end else begin
            if (next_state != state) begin
                cnt <= RELOAD;
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end

            if (load_tx) begin
                shift  <= io_din;
                bitcnt <= 3'd7;
                busy   <= 1'b1;
                si_q   <= io_din[7];
            end

            if (sample_so) begin
                shift <= {shift[6:0], rtcSpiSO};
            end

            // SI only moves as SCLK falls, so it holds steady through the high phase.
            if (next_bit) begin
                bitcnt <= bitcnt - 3'd1;
                si_q   <= shift[7];
            end

            if (finish) begin
                rx   <= shift;
                busy <= 1'b0;
                si_q <= 1'b1;
            end

            if (ctrl_wr) begin
                cs_act <= io_din[0];
            end

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign rtcSpiClk = (state != ST_SHIFT_LO);
    assign rtcSpiSI  = si_q;
    assign rtcSpiCS  = ~cs_act;
    assign rtcIntLED = ~int_n_sync;

    always_comb begin
        io_dout = rx;
        if (io_sel == SEL_CTRL) begin
            io_dout = pack_status(busy, overrun, ~int_n_sync, pwr_fail_sync, cs_act);
        end
    end

endmodule

// File: tb/tb_rtc_spi_port.sv
// tb/tb_rtc_spi_port.sv - randomized self-checking bench for rtc_spi_port
module tb_rtc_spi_port;

    localparam int CLK_DIV  = 2;
    localparam int XFER_CYC = 16 * CLK_DIV;

    logic       pll0_100MHz = 1'b0;
    logic       s100_n_RESET;
    logic       io_wr;
    logic       io_rd;
    logic       io_sel;
    logic [7:0] io_din;
    logic [7:0] io_dout;
    logic       rtcSpiSO;
    logic       rtc_n_INT;
    logic       rtcPwrFail;
    logic       rtcSpiCS;
    logic       rtcSpiClk;
    logic       rtcSpiSI;
    logic       rtcIntLED;

    int checks = 0;
    int errors = 0;

    logic       m_cs;
    logic       m_ovr;
    logic       m_int;
    logic       m_pf;
    logic [7:0] m_rx;

    rtc_spi_port #(.CLK_DIV(CLK_DIV)) dut (
        .pll0_100MHz  (pll0_100MHz),
        .s100_n_RESET (s100_n_RESET),
        .io_wr        (io_wr),
        .io_rd        (io_rd),
        .io_sel       (io_sel),
        .io_din       (io_din),
        .io_dout      (io_dout),
        .rtcSpiSO     (rtcSpiSO),
        .rtc_n_INT    (rtc_n_INT),
        .rtcPwrFail   (rtcPwrFail),
        .rtcSpiCS     (rtcSpiCS),
        .rtcSpiClk    (rtcSpiClk),
        .rtcSpiSI     (rtcSpiSI),
        .rtcIntLED    (rtcIntLED)
    );

    always #5 pll0_100MHz = ~pll0_100MHz;

    function automatic logic [7:0] exp_status(input logic busy);
        int v;
        v = (busy ? 128 : 0) + (m_ovr ? 64 : 0) + (m_int ? 4 : 0) + (m_pf ? 2 : 0) + (m_cs ? 1 : 0);
        return 8'(v);
    endfunction

    task automatic cpu_write(input logic sel, input logic [7:0] data);
        io_sel = sel;
        io_din = data;
        io_wr  = 1'b1;
        @(posedge pll0_100MHz);
        #1;
        io_wr  = 1'b0;
    endtask

    task automatic cpu_read(input logic sel, output logic [7:0] data);
        io_sel = sel;
        io_rd  = 1'b1;
        #1;
        data   = io_dout;
        @(posedge pll0_100MHz);
        #1;
        io_rd  = 1'b0;
    endtask

    task automatic peek(input logic sel, output logic [7:0] data);
        io_sel = sel;
        #1;
        data   = io_dout;
    endtask

    // Runs one byte through the port acting as the RTC slave (mode 3, MSB first).
    task automatic xfer(input logic [7:0] tx, input logic [7:0] so, input int wr_at, input int rd_at,
                        input int abort_rises, output int busy_cyc, output logic [7:0] si_bits,
                        output logic [7:0] rd_val, output int cs_changes);
        logic prev_sclk;
        logic start_cs;
        int   idx;
        int   rises;
        bit   done;
        start_cs   = rtcSpiCS;
        cpu_write(1'b0, tx);
        prev_sclk  = 1'b1;
        idx        = 0;
        rises      = 0;
        busy_cyc   = 0;
        si_bits    = 8'h00;
        rd_val     = 8'h00;
        cs_changes = 0;
        done       = 1'b0;
        for (int k = 0; k < 4000 && !done; k++) begin
            if (rtcSpiCS !== start_cs) cs_changes++;
            if (prev_sclk && !rtcSpiClk) begin
                if (idx < 8) rtcSpiSO = so[7 - idx];
                idx++;
            end
            if (!prev_sclk && rtcSpiClk) begin
                si_bits = {si_bits[6:0], rtcSpiSI};
                rises++;
            end
            prev_sclk = rtcSpiClk;
            if (abort_rises > 0 && rises == abort_rises) begin
                s100_n_RESET = 1'b0;
                done = 1'b1;
            end else begin
                io_sel = 1'b1;
                #1;
                if (!io_dout[7]) begin
                    done = 1'b1;
                end else begin
                    busy_cyc++;
                    if (k == wr_at) begin
                        io_wr  = 1'b1;
                        io_sel = (k == rd_at);
                        io_din = (k == rd_at) ? 8'h00 : 8'h11;
                    end
                    if (k == rd_at) begin
                        io_rd  = 1'b1;
                        io_sel = 1'b1;
                        #1;
                        rd_val = io_dout;
                    end
                    @(posedge pll0_100MHz);
                    #1;
                    io_wr = 1'b0;
                    io_rd = 1'b0;
                end
            end
        end
        if (!done) busy_cyc = -1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        s100_n_RESET = 1'b0;
        repeat (3) @(posedge pll0_100MHz);
        #1;
        checks++; if (rtcSpiCS !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", rtcSpiCS); end
        checks++; if (rtcSpiClk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", rtcSpiClk); end
        checks++; if (rtcSpiSI !== 1'b1) begin errors++; $display("FAIL reset_si got %b want 1", rtcSpiSI); end
        checks++; if (rtcIntLED !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", rtcIntLED); end
        peek(1'b1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", d); end
        peek(1'b0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", d); end
        s100_n_RESET = 1'b1;
        m_cs = 1'b0; m_ovr = 1'b0; m_int = 1'b0; m_pf = 1'b0; m_rx = 8'h00;
        @(posedge pll0_100MHz);
        #1;
        peek(1'b1, d);
        checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL post_reset_status got %h want %h", d, exp_status(1'b0)); end
    endtask

    task automatic test_ctrl_cs();
        logic [7:0] d;
        logic [7:0] w;
        for (int i = 0; i < 5; i++) begin
            w = 8'($urandom);
            if (i == 4) w[0] = 1'b1;
            cpu_write(1'b1, w);
            m_cs = w[0];
            checks++; if (rtcSpiCS !== ~m_cs) begin errors++; $display("FAIL ctrl_cs_pin got %b want %b", rtcSpiCS, ~m_cs); end
            cpu_read(1'b1, d);
            checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL ctrl_status got %h want %h", d, exp_status(1'b0)); end
        end
    endtask

    task automatic test_spec_transfer();
        int         bc;
        int         csc;
        logic [7:0] si;
        logic [7:0] rv;
        logic [7:0] d;
        xfer(8'hA5, 8'h3C, -1, -1, 0, bc, si, rv, csc);
        m_rx = 8'h3C;
        checks++; if (bc != XFER_CYC) begin errors++; $display("FAIL spec_busy_cycles got %0d want %0d", bc, XFER_CYC); end
        checks++; if (si !== 8'hA5) begin errors++; $display("FAIL spec_si_bits got %h want a5", si); end
        checks++; if (csc != 0 || rtcSpiCS !== 1'b0) begin errors++; $display("FAIL spec_cs_held got changes=%0d pin=%b want 0/0", csc, rtcSpiCS); end
        cpu_read(1'b0, d);
        checks++; if (d !== m_rx) begin errors++; $display("FAIL spec_rx got %h want %h", d, m_rx); end
        checks++; if (rtcSpiSI !== 1'b1) begin errors++; $display("FAIL spec_si_idle got %b want 1", rtcSpiSI); end
    endtask

    task automatic test_back_to_back();
        int         bc;
        int         csc;
        logic [7:0] si;
        logic [7:0] rv;
        logic [7:0] d;
        logic [7:0] tx;
        logic [7:0] so;
        for (int i = 0; i < 6; i++) begin
            tx = 8'($urandom);
            so = 8'($urandom);
            xfer(tx, so, -1, -1, 0, bc, si, rv, csc);
            m_rx = so;
            checks++; if (bc != XFER_CYC) begin errors++; $display("FAIL b2b_busy_cycles[%0d] got %0d want %0d", i, bc, XFER_CYC); end
            checks++; if (si !== tx) begin errors++; $display("FAIL b2b_si_bits[%0d] got %h want %h", i, si, tx); end
            checks++; if (csc != 0) begin errors++; $display("FAIL b2b_cs_held[%0d] got %0d changes want 0", i, csc); end
            cpu_read(1'b0, d);
            checks++; if (d !== m_rx) begin errors++; $display("FAIL b2b_rx[%0d] got %h want %h", i, d, m_rx); end
        end
        cpu_read(1'b1, d);
        checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL b2b_status got %h want %h", d, exp_status(1'b0)); end
    endtask

    task automatic test_overrun_ignored();
        int         bc;
        int         csc;
        logic [7:0] si;
        logic [7:0] rv;
        logic [7:0] d;
        logic [7:0] tx;
        logic [7:0] so;
        tx = 8'($urandom);
        so = 8'($urandom);
        xfer(tx, so, 5, 10, 0, bc, si, rv, csc);
        m_ovr = 1'b1;
        checks++; if (rv !== exp_status(1'b1)) begin errors++; $display("FAIL ovr_status_mid got %h want %h", rv, exp_status(1'b1)); end
        m_ovr = 1'b0;
        m_rx  = so;
        checks++; if (si !== tx) begin errors++; $display("FAIL ovr_orig_byte got %h want %h", si, tx); end
        checks++; if (bc != XFER_CYC) begin errors++; $display("FAIL ovr_busy_cycles got %0d want %0d", bc, XFER_CYC); end
        cpu_read(1'b1, d);
        checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL ovr_status_after got %h want %h", d, exp_status(1'b0)); end
        cpu_read(1'b0, d);
        checks++; if (d !== m_rx) begin errors++; $display("FAIL ovr_rx got %h want %h", d, m_rx); end
    endtask

    task automatic test_status_set_wins();
        int         bc;
        int         csc;
        logic [7:0] si;
        logic [7:0] rv;
        logic [7:0] d;
        logic [7:0] so;
        so = 8'($urandom) | 8'h01;
        xfer(8'($urandom), so, 6, 6, 0, bc, si, rv, csc);
        checks++; if (rv !== exp_status(1'b1)) begin errors++; $display("FAIL setwins_read got %h want %h", rv, exp_status(1'b1)); end
        m_ovr = 1'b1;
        m_rx  = so;
        checks++; if (csc != 0) begin errors++; $display("FAIL setwins_cs_held got %0d changes want 0", csc); end
        peek(1'b1, d);
        checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL setwins_ovr_kept got %h want %h", d, exp_status(1'b0)); end
        cpu_read(1'b1, d);
        m_ovr = 1'b0;
        peek(1'b1, d);
        checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL setwins_cleared got %h want %h", d, exp_status(1'b0)); end
    endtask

    task automatic test_data_read_no_side_effect();
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] s;
        cpu_read(1'b0, d1);
        cpu_read(1'b0, d2);
        checks++; if (d1 !== m_rx || d2 !== m_rx) begin errors++; $display("FAIL data_reread got %h/%h want %h", d1, d2, m_rx); end
        peek(1'b1, s);
        checks++; if (s !== exp_status(1'b0)) begin errors++; $display("FAIL data_read_status got %h want %h", s, exp_status(1'b0)); end
    endtask

    task automatic test_async_status();
        logic [7:0] d;
        int         n;
        @(posedge pll0_100MHz);
        #($urandom_range(1, 8));
        rtc_n_INT = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pll0_100MHz);
            #1;
            n++;
            if (rtcIntLED === 1'b1) break;
        end
        m_int = 1'b1;
        checks++; if (n < 2 || n > 3 || rtcIntLED !== 1'b1) begin errors++; $display("FAIL int_led_latency got %0d clocks led=%b want 2..3", n, rtcIntLED); end
        peek(1'b1, d);
        checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL int_status got %h want %h", d, exp_status(1'b0)); end
        @(posedge pll0_100MHz);
        #($urandom_range(1, 8));
        rtcPwrFail = 1'b1;
        n = 0;
        io_sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge pll0_100MHz);
            #1;
            n++;
            if (io_dout[1] === 1'b1) break;
        end
        m_pf = 1'b1;
        checks++; if (n < 2 || n > 3) begin errors++; $display("FAIL pwrfail_latency got %0d clocks want 2..3", n); end
        peek(1'b1, d);
        checks++; if (d !== exp_status(1'b0)) begin errors++; $display("FAIL pwrfail_status got %h want %h", d, exp_status(1'b0)); end
        rtc_n_INT  = 1'b1;
        rtcPwrFail = 1'b0;
        repeat (4) @(posedge pll0_100MHz);
        #1;
        m_int = 1'b0;
        m_pf  = 1'b0;
        peek(1'b1, d);
        checks++; if (d !== exp_status(1'b0) || rtcIntLED !== 1'b0) begin errors++; $display("FAIL pins_released got %h led=%b want %h led=0", d, rtcIntLED, exp_status(1'b0)); end
    endtask

    task automatic test_reset_mid_transfer();
        int         bc;
        int         csc;
        logic [7:0] si;
        logic [7:0] rv;
        logic [7:0] d;
        xfer(8'hFF, 8'($urandom), -1, -1, 3, bc, si, rv, csc);
        checks++; if (bc <= 0) begin errors++; $display("FAIL abort_reached got %0d busy clocks want >0", bc); end
        #1;
        checks++; if (rtcSpiClk !== 1'b1 || rtcSpiCS !== 1'b1 || rtcSpiSI !== 1'b1) begin errors++; $display("FAIL abort_pins got sclk=%b cs=%b si=%b want 1/1/1", rtcSpiClk, rtcSpiCS, rtcSpiSI); end
        m_cs = 1'b0; m_ovr = 1'b0; m_rx = 8'h00;
        peek(1'b1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL abort_status got %h want 00", d); end
        peek(1'b0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL abort_data got %h want 00", d); end
        repeat (2) @(posedge pll0_100MHz);
        #1;
        s100_n_RESET = 1'b1;
        repeat (40) @(posedge pll0_100MHz);
        #1;
        peek(1'b0, d);
        checks++; if (d !== m_rx) begin errors++; $display("FAIL abort_no_partial_rx got %h want %h", d, m_rx); end
        peek(1'b1, d);
        checks++; if (d !== exp_status(1'b0) || rtcSpiClk !== 1'b1) begin errors++; $display("FAIL abort_idle got %h sclk=%b want %h sclk=1", d, rtcSpiClk, exp_status(1'b0)); end
    endtask

    task automatic test_recovery();
        int         bc;
        int         csc;
        logic [7:0] si;
        logic [7:0] rv;
        logic [7:0] d;
        logic [7:0] tx;
        logic [7:0] so;
        cpu_write(1'b1, 8'h01);
        m_cs = 1'b1;
        tx = 8'($urandom);
        so = 8'($urandom);
        xfer(tx, so, -1, -1, 0, bc, si, rv, csc);
        m_rx = so;
        checks++; if (bc != XFER_CYC || si !== tx) begin errors++; $display("FAIL recover_xfer got %0d/%h want %0d/%h", bc, si, XFER_CYC, tx); end
        cpu_read(1'b0, d);
        checks++; if (d !== m_rx) begin errors++; $display("FAIL recover_rx got %h want %h", d, m_rx); end
    endtask

    initial begin
        io_wr      = 1'b0;
        io_rd      = 1'b0;
        io_sel     = 1'b0;
        io_din     = 8'h00;
        rtcSpiSO   = 1'b1;
        rtc_n_INT  = 1'b1;
        rtcPwrFail = 1'b0;
        s100_n_RESET = 1'b0;
        #2;
        test_reset();
        test_ctrl_cs();
        test_spec_transfer();
        test_back_to_back();
        test_overrun_ignored();
        test_status_set_wins();
        test_data_read_no_side_effect();
        test_async_status();
        test_reset_mid_transfer();
        test_recovery();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
